// File: rtl/tipi_pkg.sv
// TIPI nibble-bus host: shared state encoding, register codes, CMD nibble layout.
package tipi_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SYNC = 3'd1,
    S_CMD  = 3'd2,
    S_DHI  = 3'd3,
    S_DLO  = 3'd4,
    S_DONE = 3'd5
  } state_e;

  localparam logic [1:0] SEL_RD = 2'b00;
  localparam logic [1:0] SEL_RC = 2'b01;
  localparam logic [1:0] SEL_TD = 2'b10;
  localparam logic [1:0] SEL_TC = 2'b11;

  localparam int CMD_WR_BIT  = 3;
  localparam int CMD_SEL_MSB = 1;
  localparam int CMD_SEL_LSB = 0;

  // RD and RC are written by the Pi; TD and TC belong to the TI side
  function automatic logic pi_owned(logic [1:0] sel);
    return (sel == SEL_RD) || (sel == SEL_RC);
  endfunction

  function automatic logic [3:0] cmd_nib(logic wr, logic [1:0] sel);
    logic [3:0] n;
    n = 4'h0;
    n[CMD_WR_BIT] = wr;
    n[CMD_SEL_MSB:CMD_SEL_LSB] = sel;
    return n;
  endfunction

endpackage

// File: rtl/tipi_nib_host_if.sv
// Request/response handshake between a bus master and the TIPI nibble host.
interface tipi_nib_host_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [1:0] cmd_sel;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;

  modport master (
    output cmd_valid, cmd_write, cmd_sel, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_sel, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, busy
  );
endinterface

// File: rtl/tipi_nib_phase.sv
// r_clk half-period counter: low phase then high phase, cleared while idle.
module tipi_nib_phase #(
  parameter int HALF_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic phase_lo,
  output logic phase_hi,
  output logic last_lo,
  output logic last_hi
);

  localparam logic [7:0] LAST = 8'(HALF_CYC - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       hi_q, hi_d;
  logic       wrap;

  assign wrap = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    hi_d  = hi_q;
    if (!run) begin
      cnt_d = 8'h00;
      hi_d  = 1'b0;
    end else if (wrap) begin
      cnt_d = 8'h00;
      hi_d  = ~hi_q;
    end else begin
      cnt_d = cnt_q + 8'h01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'h00;
      hi_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
    end
  end

  assign phase_lo = run & ~hi_q;
  assign phase_hi = run & hi_q;
  assign last_lo  = phase_lo & wrap;
  assign last_hi  = phase_hi & wrap;

endmodule

// File: rtl/tipi_nib_host.sv
// TIPI nibble-bus host: one register access per request, SYNC/CMD/DHI/DLO frames.
import tipi_pkg::*;

module tipi_nib_host #(
  parameter int HALF_CYC = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  tipi_nib_host_if.slave  bus,
  output logic            r_clk,
  output logic            r_nibrst,
  output logic [3:0]      r_nib_o,
  output logic            r_nib_oe,
  input  logic [3:0]      r_nib_i
);

  state_e     state_q, state_d;
  logic       init_q;
  logic       wr_q;
  logic [1:0] sel_q;
  logic [7:0] wdata_q;
  logic [3:0] hi_nib_q;
  logic [7:0] rsp_q;

  logic       run, accept, drive;
  logic       phase_lo, phase_hi, last_lo, last_hi;
  logic       unused_lo;
  logic [3:0] nib;
  logic       oe;

  assign run    = state_q inside {S_SYNC, S_CMD, S_DHI, S_DLO};
  assign accept = bus.cmd_valid & bus.cmd_ready;
  // writes to TI-owned registers fall back to a read of the data phases
  assign drive  = wr_q & pi_owned(sel_q);
  assign unused_lo = phase_lo ^ last_lo;

  tipi_nib_phase #(
    .HALF_CYC (HALF_CYC)
  ) u_phase (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .phase_lo (phase_lo),
    .phase_hi (phase_hi),
    .last_lo  (last_lo),
    .last_hi  (last_hi)
  );

  always_comb begin
    state_d = state_q;
    nib     = 4'h0;
    oe      = 1'b0;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_SYNC;
      S_SYNC: if (last_hi) state_d = S_CMD;
      S_CMD: begin
        nib = cmd_nib(wr_q, sel_q);
        oe  = 1'b1;
        if (last_hi) state_d = S_DHI;
      end
      S_DHI: begin
        if (drive) begin
          nib = wdata_q[7:4];
          oe  = 1'b1;
        end
        if (last_hi) state_d = S_DLO;
      end
      S_DLO: begin
        if (drive) begin
          nib = wdata_q[3:0];
          oe  = 1'b1;
        end
        if (last_hi) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      init_q   <= 1'b0;
      wr_q     <= 1'b0;
      sel_q    <= SEL_RD;
      wdata_q  <= 8'h00;
      hi_nib_q <= 4'h0;
      rsp_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
      if (accept) begin
        wr_q    <= bus.cmd_write;
        sel_q   <= bus.cmd_sel;
        wdata_q <= bus.cmd_wdata;
      end
      if (state_q == S_DHI && last_hi) hi_nib_q <= r_nib_i;
      if (state_q == S_DLO && last_hi)
        rsp_q <= drive ? 8'h00 : {hi_nib_q, r_nib_i};
    end
  end

  assign bus.cmd_ready = init_q & (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.rsp_valid = (state_q == S_DONE);
  assign bus.rsp_rdata = rsp_q;

  assign r_clk    = phase_hi;
  assign r_nibrst = (state_q == S_SYNC);
  assign r_nib_o  = nib;
  assign r_nib_oe = oe;

endmodule

// File: tb/tb_tipi_nib_host.sv
// Bench for tipi_nib_host: device model, expected-data queue, latency checks.
import tipi_pkg::*;

module tb_tipi_nib_host;

  logic clk = 1'b0;
  logic rst_a_n = 1'b0;
  logic rst_b_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tipi_nib_host_if ia ();
  tipi_nib_host_if ib ();

  logic       a_rclk, a_nibrst, a_oe;
  logic [3:0] a_nib_o, a_nib_i;
  logic       b_rclk, b_nibrst, b_oe;
  logic [3:0] b_nib_o;
  logic [3:0] b_nib_i = 4'h0;

  tipi_nib_host #(.HALF_CYC(4)) dut_a (
    .clk      (clk),
    .rst_n    (rst_a_n),
    .bus      (ia.slave),
    .r_clk    (a_rclk),
    .r_nibrst (a_nibrst),
    .r_nib_o  (a_nib_o),
    .r_nib_oe (a_oe),
    .r_nib_i  (a_nib_i)
  );

  tipi_nib_host #(.HALF_CYC(2)) dut_b (
    .clk      (clk),
    .rst_n    (rst_b_n),
    .bus      (ib.slave),
    .r_clk    (b_rclk),
    .r_nibrst (b_nibrst),
    .r_nib_o  (b_nib_o),
    .r_nib_oe (b_oe),
    .r_nib_i  (b_nib_i)
  );

  // device model: r_clk rises after nibble reset select CMD=1, DHI=2, DLO=3
  logic [7:0] dev_a = 8'h00;
  logic [2:0] a_ph = 3'd0;
  logic [3:0] nib_log[$];
  int         a_oe_data = 0;
  int         a_rst_hi = 0;
  int         a_rsp_cnt = 0;
  int         b_rsp_cnt = 0;
  logic [7:0] exp_q[$];

  always @(posedge a_rclk or posedge a_nibrst)
    if (a_nibrst) a_ph <= 3'd0;
    else          a_ph <= a_ph + 3'd1;

  assign a_nib_i = (a_ph == 3'd2) ? dev_a[7:4] :
                   (a_ph == 3'd3) ? dev_a[3:0] : 4'h0;

  always @(posedge a_rclk) if (a_oe) nib_log.push_back(a_nib_o);

  always @(negedge clk) begin
    if (a_oe && ((a_ph == 3'd1 && !a_rclk) || a_ph >= 3'd2))
      a_oe_data = a_oe_data + 1;
    if (a_nibrst) a_rst_hi = a_rst_hi + 1;
  end

  always @(posedge clk) begin
    if (ia.rsp_valid) a_rsp_cnt <= a_rsp_cnt + 1;
    if (ib.rsp_valid) b_rsp_cnt <= b_rsp_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time=%0t limit reached", $time);
    $fatal(1, "watchdog");
  end

  task automatic a_issue(input logic wr, input logic [1:0] sel,
                         input logic [7:0] wd, output int acc);
    int n;
    n = 0;
    ia.cmd_valid = 1'b1;
    ia.cmd_write = wr;
    ia.cmd_sel   = sel;
    ia.cmd_wdata = wd;
    while (!ia.cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (ia.cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL accept_a: cmd_ready=%b want 1", ia.cmd_ready);
    end
    acc = cyc;
    @(negedge clk);
    ia.cmd_valid = 1'b0;
  endtask

  task automatic a_wait(output logic [7:0] d, output int at);
    int n;
    n = 0;
    while (!ia.rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (ia.rsp_valid !== 1'b1) begin
      bad++;
      $display("FAIL rsp_timeout_a: rsp_valid=%b want 1", ia.rsp_valid);
    end
    d  = ia.rsp_valid ? ia.rsp_rdata : 8'hxx;
    at = cyc;
  endtask

  task automatic test_reset;
    logic [15:0] va, vb;
    ia.cmd_valid = 1'b0; ia.cmd_write = 1'b0;
    ia.cmd_sel = 2'b00;  ia.cmd_wdata = 8'h00;
    ib.cmd_valid = 1'b0; ib.cmd_write = 1'b0;
    ib.cmd_sel = 2'b00;  ib.cmd_wdata = 8'h00;
    repeat (3) @(negedge clk);
    va = {ia.cmd_ready, ia.busy, ia.rsp_valid, ia.rsp_rdata,
          a_rclk, a_nibrst, a_nib_o == 4'h0 ? 1'b0 : 1'b1, a_oe};
    vb = {ib.cmd_ready, ib.busy, ib.rsp_valid, ib.rsp_rdata,
          b_rclk, b_nibrst, b_nib_o == 4'h0 ? 1'b0 : 1'b1, b_oe};
    total++;
    if (va !== 16'h0000) begin
      bad++; $display("FAIL reset_a: outs=%h want 0000", va);
    end
    total++;
    if (vb !== 16'h0000) begin
      bad++; $display("FAIL reset_b: outs=%h want 0000", vb);
    end
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    @(negedge clk);
    total++;
    if ({ia.cmd_ready, ib.cmd_ready} !== 2'b11) begin
      bad++;
      $display("FAIL ready_after_reset: got %b want 11",
               {ia.cmd_ready, ib.cmd_ready});
    end
  endtask

  task automatic test_write_rd;
    int acc, at, s0, r0;
    logic [7:0] d, e;
    logic [11:0] got;
    s0 = nib_log.size();
    r0 = a_rst_hi;
    exp_q.push_back(8'h00);
    a_issue(1'b1, SEL_RD, 8'hA5, acc);
    a_wait(d, at);
    e = exp_q.pop_front();
    total++;
    if (d !== e) begin
      bad++; $display("FAIL wr_rd_data: got %h want %h", d, e);
    end
    total++;
    if (at - acc !== 33) begin
      bad++; $display("FAIL wr_rd_latency: got %0d want 33", at - acc);
    end
    got = (nib_log.size() == s0 + 3) ?
          {nib_log[s0], nib_log[s0+1], nib_log[s0+2]} : 12'hxxx;
    total++;
    if (got !== 12'h8A5) begin
      bad++; $display("FAIL wr_rd_nibbles: got %h want 8a5", got);
    end
    total++;
    if (a_rst_hi - r0 !== 8) begin
      bad++; $display("FAIL wr_rd_nibrst: got %0d want 8", a_rst_hi - r0);
    end
  endtask

  task automatic test_read_tc;
    int acc, at, o0, s0;
    logic [7:0] d, e;
    dev_a = 8'h3C;
    o0 = a_oe_data;
    s0 = nib_log.size();
    exp_q.push_back(8'h3C);
    a_issue(1'b0, SEL_TC, 8'h00, acc);
    a_wait(d, at);
    e = exp_q.pop_front();
    total++;
    if (d !== e) begin
      bad++; $display("FAIL rd_tc_data: got %h want %h", d, e);
    end
    total++;
    if (a_oe_data - o0 !== 0) begin
      bad++; $display("FAIL rd_tc_oe: data-phase oe cycles %0d want 0",
                      a_oe_data - o0);
    end
    total++;
    if (nib_log.size() != s0 + 1 || nib_log[s0] !== 4'h3) begin
      bad++; $display("FAIL rd_tc_cmd: count %0d want 1 nibble 3",
                      nib_log.size() - s0);
    end
  endtask

  task automatic test_write_td;
    int acc, at, o0;
    logic [7:0] d, e;
    dev_a = 8'h12;
    o0 = a_oe_data;
    exp_q.push_back(8'h12);
    a_issue(1'b1, SEL_TD, 8'hFF, acc);
    a_wait(d, at);
    e = exp_q.pop_front();
    total++;
    if (d !== e) begin
      bad++; $display("FAIL wr_td_data: got %h want %h", d, e);
    end
    total++;
    if (a_oe_data - o0 !== 0) begin
      bad++; $display("FAIL wr_td_oe: data-phase oe cycles %0d want 0",
                      a_oe_data - o0);
    end
    total++;
    if (at - acc !== 33) begin
      bad++; $display("FAIL wr_td_latency: got %0d want 33", at - acc);
    end
  endtask

  task automatic test_back_to_back;
    int acc1, at1, acc2, at2;
    logic [7:0] d1, d2, e;
    dev_a = 8'h7E;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h7E);
    a_issue(1'b1, SEL_RC, 8'h01, acc1);
    a_wait(d1, at1);
    a_issue(1'b0, SEL_TD, 8'h00, acc2);
    a_wait(d2, at2);
    e = exp_q.pop_front();
    total++;
    if (d1 !== e) begin
      bad++; $display("FAIL b2b_first: got %h want %h", d1, e);
    end
    e = exp_q.pop_front();
    total++;
    if (d2 !== e) begin
      bad++; $display("FAIL b2b_second: got %h want %h", d2, e);
    end
    total++;
    if (acc2 - at1 !== 1) begin
      bad++; $display("FAIL b2b_gap: got %0d want 1", acc2 - at1);
    end
    total++;
    if (at2 - acc2 !== 33) begin
      bad++; $display("FAIL b2b_latency: got %0d want 33", at2 - acc2);
    end
  endtask

  task automatic test_reset_mid;
    int acc, at, r0, s0;
    logic [7:0] d, e;
    logic [15:0] v;
    logic [11:0] got;
    a_issue(1'b1, SEL_RC, 8'h5A, acc);
    while (cyc < acc + 20) @(negedge clk);
    total++;
    if (a_oe !== 1'b1 || a_nib_o !== 4'h5) begin
      bad++; $display("FAIL mid_dhi: oe=%b nib=%h want 1 5", a_oe, a_nib_o);
    end
    r0 = a_rsp_cnt;
    #2 rst_a_n = 1'b0;
    #1;
    v = {ia.cmd_ready, ia.busy, ia.rsp_valid, ia.rsp_rdata,
         a_rclk, a_nibrst, a_nib_o == 4'h0 ? 1'b0 : 1'b1, a_oe};
    total++;
    if (v !== 16'h0000) begin
      bad++; $display("FAIL mid_async_reset: outs=%h want 0000", v);
    end
    repeat (3) @(negedge clk);
    rst_a_n = 1'b1;
    @(negedge clk);
    total++;
    if (a_rsp_cnt !== r0 || ia.cmd_ready !== 1'b1) begin
      bad++; $display("FAIL mid_abort: rsp=%0d ready=%b want 0 1",
                      a_rsp_cnt - r0, ia.cmd_ready);
    end
    s0 = nib_log.size();
    exp_q.push_back(8'h00);
    a_issue(1'b1, SEL_RD, 8'h33, acc);
    a_wait(d, at);
    e = exp_q.pop_front();
    got = (nib_log.size() == s0 + 3) ?
          {nib_log[s0], nib_log[s0+1], nib_log[s0+2]} : 12'hxxx;
    total++;
    if (d !== e || at - acc !== 33 || got !== 12'h833) begin
      bad++; $display("FAIL mid_recover: data=%h lat=%0d nib=%h want %h 33 833",
                      d, at - acc, got, e);
    end
  endtask

  task automatic test_half2;
    int acc, at, n, b0;
    logic [7:0] d, e;
    b0 = b_rsp_cnt;
    exp_q.push_back(8'h00);
    ib.cmd_valid = 1'b1; ib.cmd_write = 1'b0;
    ib.cmd_sel = SEL_RD; ib.cmd_wdata = 8'h00;
    n = 0;
    while (!ib.cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    acc = cyc;
    @(negedge clk);
    ib.cmd_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      ib.cmd_valid = 1'b1; ib.cmd_write = 1'b1;
      ib.cmd_sel = SEL_TC; ib.cmd_wdata = 8'hC3;
      total++;
      if (ib.cmd_ready !== 1'b0 || ib.busy !== 1'b1) begin
        bad++; $display("FAIL h2_busy_%0d: ready=%b busy=%b want 0 1",
                        i, ib.cmd_ready, ib.busy);
      end
      @(negedge clk);
      ib.cmd_valid = 1'b0;
      @(negedge clk);
    end
    n = 0;
    while (!ib.rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    d  = ib.rsp_valid ? ib.rsp_rdata : 8'hxx;
    at = cyc;
    e  = exp_q.pop_front();
    total++;
    if (d !== e) begin
      bad++; $display("FAIL h2_data: got %h want %h", d, e);
    end
    total++;
    if (at - acc !== 17) begin
      bad++; $display("FAIL h2_latency: got %0d want 17", at - acc);
    end
    repeat (40) @(negedge clk);
    total++;
    if (b_rsp_cnt - b0 !== 1 || ib.busy !== 1'b0) begin
      bad++; $display("FAIL h2_ignored: rsp=%0d busy=%b want 1 0",
                      b_rsp_cnt - b0, ib.busy);
    end
  endtask

  initial begin
    test_reset();
    test_write_rd();
    test_read_tc();
    test_write_td();
    test_back_to_back();
    test_reset_mid();
    test_half2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tipi_nib_host.md
TIPI_NIB_HOST -- requirements
Module: tipi_nib_host

Interface
REQ-001 SHALL have parameter HALF_CYC, default 4, meaning clk cycles per r_clk half-period (legal range 2..255).
REQ-002 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port cmd_valid  input  1  a transaction request is present.
REQ-005 SHALL have port cmd_ready  output  1  the block accepts a request this cycle.
REQ-006 SHALL have port cmd_write  input  1  1 = write a Pi-owned register, 0 = read a register.
REQ-007 SHALL have port cmd_sel  input  2  register select: 00 RD, 01 RC, 10 TD, 11 TC.
REQ-008 SHALL have port cmd_wdata  input  8  write data.
REQ-009 SHALL have port rsp_valid  output  1  one-cycle pulse at transaction completion.
REQ-010 SHALL have port rsp_rdata  output  8  read data; 8'h00 for writes.
REQ-011 SHALL have port busy  output  1  a transaction is in progress.
REQ-012 SHALL have port r_clk  output  1  nibble-bus clock to the TIPI device.
REQ-013 SHALL have port r_nibrst  output  1  nibble-bus shifter reset, active high.
REQ-014 SHALL have port r_nib_o  output  4  nibble driven by the host.
REQ-015 SHALL have port r_nib_oe  output  1  output enable for r_nib_o (pad tristate control).
REQ-016 SHALL have port r_nib_i  input  4  nibble returned by the TIPI device.

Function
REQ-017 SHALL assert cmd_ready only in IDLE; a request is accepted when cmd_valid and cmd_ready are both high, and cmd_write/cmd_sel/cmd_wdata are captured then.
REQ-018 SHALL sequence states IDLE -> SYNC -> CMD -> DHI -> DLO -> DONE -> IDLE; each of SYNC, CMD, DHI, DLO lasts exactly 2*HALF_CYC cycles: r_clk low for HALF_CYC, then high for HALF_CYC.
REQ-019 SHALL hold r_nibrst high for the whole of SYNC and low in every other state.
REQ-020 SHALL drive in CMD r_nib_o = {cmd_write, 1'b0, cmd_sel} with r_nib_oe = 1.
REQ-021 SHALL, for writes, drive cmd_wdata[7:4] in DHI and cmd_wdata[3:0] in DLO with r_nib_oe = 1, changing r_nib_o only while r_clk is low.
REQ-022 SHALL, for reads, hold r_nib_oe = 0 in DHI and DLO, and sample r_nib_i on the last clk of each r_clk-high phase, into rdata[7:4] in DHI and into rdata[3:0] in DLO.
REQ-023 SHALL reject a write to TD or TC, which are TI-owned: the transaction still runs, but DHI/DLO behave as a read, and rsp_rdata returns the sampled value.
REQ-024 SHALL spend one cycle in DONE, pulsing rsp_valid with rsp_rdata stable, then return to IDLE; total latency from acceptance to rsp_valid is 8*HALF_CYC+1 cycles (33 at the default).
REQ-025 SHALL hold rsp_rdata until the next rsp_valid.
REQ-026 SHALL assert busy in every state except IDLE; cmd_valid while busy is ignored (no queueing).
REQ-027 SHALL allow back-to-back requests: a request accepted in the cycle after DONE starts SYNC on the next cycle.
REQ-028 SHALL keep r_clk low in IDLE and DONE, and drive r_nib_oe = 0 in IDLE, SYNC and DONE.

Reset
REQ-029 SHALL, while rst_n is low, force state IDLE, r_clk 0, r_nibrst 0, r_nib_o 4'h0, r_nib_oe 0, rsp_valid 0, rsp_rdata 8'h00, busy 0, cmd_ready 0, and clear the half-period counter.
REQ-030 SHALL abort any transaction in flight when rst_n is asserted mid-operation, with no rsp_valid; cmd_ready rises on the first clk edge after rst_n deasserts.

Structure
REQ-031 SHALL place the state encoding, the cmd_sel register codes (RD, RC, TD, TC), and the CMD-nibble bit positions in shared package tipi_pkg.
REQ-032 SHALL implement the r_clk phase/half-period counter as sub-module tipi_nib_phase, which outputs phase_lo, phase_hi, last_lo and last_hi strobes.

Verification
REQ-033 SHALL check a write to RD with data 8'hA5 at HALF_CYC=4: the nibble sequence on r_clk rising edges is CMD 4'h8, then 4'hA, then 4'h5; r_nibrst is high for 8 cycles; rsp_valid arrives 33 cycles after acceptance.
REQ-034 SHALL check a read of TC with the device model returning 8'h3C: r_nib_oe = 0 in DHI and DLO; rsp_rdata = 8'h3C.
REQ-035 SHALL check a write attempt to TD with cmd_wdata 8'hFF while the model holds 8'h12: r_nib_oe never rises in data phases; rsp_rdata = 8'h12.
REQ-036 SHALL check back-to-back transactions (write RC 8'h01, then read TD 8'h7E): no idle gap beyond the DONE cycle plus the acceptance cycle; both responses are correct.
REQ-037 SHALL check assertion of rst_n during DHI of a write: all outputs take reset values asynchronously, no rsp_valid is produced, and the next transaction completes normally.
REQ-038 SHALL check HALF_CYC=2 with a read of RD returning 8'h00: latency is 17 cycles, and cmd_valid pulses while busy are ignored.
